fetch_stage: RTL

- Instruction fetch front end; sits directly upstream of the fetch-to-decode skid buffer and feeds it a valid/ready stream of {pc, instr}.
- Generates sequential PCs and issues requests to a fixed 1-cycle-latency instruction memory.
- Buffers returned instructions in a small FIFO so downstream backpressure never loses a response.
- Applies redirects from the backend (mispredict/exception), flushing queued and in-flight fetches.

---
 rtl/fetch_stage.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch front end: sequential PC generation, 1-cycle imem requests,
// response FIFO toward the decode skid buffer, and backend redirect/flush.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 3
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        valid_out,
   input  logic        ready_in,
   output logic [31:0] pc_out,
   output logic [31:0] instr_out
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [31:0]      pc_q, pc_d;
   logic             inflight_q, inflight_d;
   logic [31:0]      inflight_pc_q, inflight_pc_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      fifo_pc_q    [DEPTH];
   logic [31:0]      fifo_pc_d    [DEPTH];
   logic [31:0]      fifo_instr_q [DEPTH];
   logic [31:0]      fifo_instr_d [DEPTH];

   logic issue;
   logic push;
   logic pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      valid_out      = !reset && (count_q != '0);
      pc_out         = fifo_pc_q[rd_ptr_q];
      instr_out      = fifo_instr_q[rd_ptr_q];
      // Occupancy plus in-flight cap guarantees every response has a free slot.
      issue          = !reset && !redirect_valid &&
                       ((32'(count_q) + 32'(inflight_q)) < DEPTH);
      imem_req_valid = issue;
      imem_req_addr  = pc_q;
      push           = inflight_q && !redirect_valid;
      pop            = valid_out && ready_in && !redirect_valid;
   end

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      fifo_pc_d     = fifo_pc_q;
      fifo_instr_d  = fifo_instr_q;

      if (redirect_valid) begin
         pc_d     = redirect_pc & 32'hFFFF_FFFC;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (issue) begin
            pc_d          = pc_q + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
         end
         if (push) begin
            fifo_pc_d[wr_ptr_q]    = inflight_pc_q;
            fifo_instr_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d               = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
   end

   push_never_full: assert property (@(posedge clk) disable iff (reset)
      !(push && (count_q == CNT_W'(DEPTH))));

endmodule
